sr_reg_bank: RTL

Parametrised bank of WIDTH clocked set/reset storage bits with a selectable conflict-resolution mode, a global clock enable, per-bit edge pulses and sticky conflict reporting. It is the general-purpose status/flag register used wherever single SR flip-flops were previously instantiated bit by bit. Every output has a defined value in every mode, including when S and R are both asserted.

---
 rtl/sr_bank_pkg.sv | 33 +++
 rtl/sr_bank_cell.sv | 43 ++++
 rtl/sr_reg_bank.sv | 81 ++++++++
 3 files changed

// File: rtl/sr_bank_pkg.sv
// Shared types and next-state rule for the SR flag register bank.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  // Next value of one SR bit; the mode only matters when s and r are both set.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00: nxt = q;
      2'b01: nxt = 1'b0;
      2'b10: nxt = 1'b1;
      default: begin
        case (mode)
          SR_HOLD:    nxt = q;
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_bank_cell.sv
// One SR storage bit with registered rise/fall pulses and a conflict flag.
module sr_bank_cell
  import sr_bank_pkg::*;
#(
  parameter sr_mode_e MODE    = SR_HOLD,
  parameter logic     RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict_c
);

  logic nxt_c;

  // Disabled cells present their own value, which also forces both pulses low.
  always_comb begin
    nxt_c = q;
    if (en) begin
      nxt_c = sr_next(q, s, r, MODE);
    end
  end

  assign conflict_c = en & s & r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= RST_VAL;
      q_rise <= 1'b0;
      q_fall <= 1'b0;
    end else begin
      q      <= nxt_c;
      q_rise <= ~q & nxt_c;
      q_fall <= q & ~nxt_c;
    end
  end

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH SR flag bits with sticky conflict error.
// Define SR_BANK_CONFLICT_CNT_EN to build the saturating conflict counter.
module sr_reg_bank
  import sr_bank_pkg::*;
#(
  parameter int unsigned          WIDTH   = 8,
  parameter int                   MODE    = 0,
  parameter logic [WIDTH-1:0]     RST_VAL = '0,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic             err,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_reg_bank: MODE %0d out of range 0..3", MODE);
  end

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_reg_bank: WIDTH %0d out of range 1..64", WIDTH);
  end

  localparam sr_mode_e MODE_E = sr_mode_e'(2'(MODE));

  logic [WIDTH-1:0] conflict_vec_c;
  logic             any_conflict_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_bank_cell #(
      .MODE    (MODE_E),
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .s          (s[i]),
      .r          (r[i]),
      .q          (q[i]),
      .q_rise     (q_rise[i]),
      .q_fall     (q_fall[i]),
      .conflict_c (conflict_vec_c[i])
    );
  end

  assign any_conflict_c = |conflict_vec_c;

  // A conflict in the clearing cycle wins so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= any_conflict_c | (err & ~clr_err);
    end
  end

`ifdef SR_BANK_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (clr_err) begin
      conflict_cnt <= any_conflict_c ? CNT_W'(1) : '0;
    end else if (any_conflict_c && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule
